pipe_stage_reg: RTL and testbench

//   Parametrised inter-stage pipeline register for the CPU datapath (EX/MEM, MEM/WB, ID/EX).

---
 rtl/pipe_stage_reg_pkg.sv | 25 ++
 rtl/pipe_stage_reg_if.sv | 40 ++++
 rtl/pipe_stage_reg_skid_slot.sv | 54 +++++
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_pkg : shared widths, control-bit indices and entry type for           |
// |            the inter-stage pipeline register.                              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package pipe_pkg;

  localparam int DEFAULT_CTRL_W = 4;
  localparam int DEFAULT_DATA_W = 65;
  localparam int DEFAULT_ADDR_W = 5;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMTOREG = 3;

  typedef struct packed {
    logic [DEFAULT_CTRL_W-1:0] ctrl;
    logic [DEFAULT_DATA_W-1:0] data;
    logic [DEFAULT_ADDR_W-1:0] rd;
  } pipe_entry_t;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_stage_reg_if : upstream/downstream handshake, hazard controls and     |
// |                     payload of one pipeline stage register.                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEFAULT_CTRL_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) ();

  logic              valid_i;
  logic              ready_o;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data_i;
  logic [ADDR_W-1:0] rd_i;
  logic              stall_i;
  logic              flush_i;
  logic              valid_o;
  logic              ready_i;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
  logic [ADDR_W-1:0] rd_o;

  // Environment side: drives upstream entry, hazard controls and downstream ready
  modport master (
    output valid_i, ctrl_i, data_i, rd_i, stall_i, flush_i, ready_i,
    input  ready_o, valid_o, ctrl_o, data_o, rd_o
  );

  modport slave (
    input  valid_i, ctrl_i, data_i, rd_i, stall_i, flush_i, ready_i,
    output ready_o, valid_o, ctrl_o, data_o, rd_o
  );

endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg_skid_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_skid_slot : one entry holding register; load wins over clear, clear   |
// |                  drops valid and zeroes the control field only.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W    = DEFAULT_CTRL_W,
  parameter int PAYLOAD_W = DEFAULT_DATA_W + DEFAULT_ADDR_W
) (
  input  wire logic                        clk_i,
  input  wire logic                        rst_i,
  input  wire logic                        load_i,
  input  wire logic                        clear_i,
  input  wire logic [CTRL_W+PAYLOAD_W-1:0] entry_i,
  output logic                             valid_o,
  output logic [CTRL_W+PAYLOAD_W-1:0]      entry_o
);

  localparam int c_ENTRY_W = CTRL_W + PAYLOAD_W;

  logic                 valid_q, valid_d;
  logic [c_ENTRY_W-1:0] entry_q, entry_d;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (load_i) begin
      valid_d = 1'b1;
      entry_d = entry_i;
    end else if (clear_i) begin
      // Payload is kept so downstream sees the last value; control must not leak
      valid_d = 1'b0;
      entry_d[c_ENTRY_W-1 -: CTRL_W] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_stage_reg : inter-stage pipeline register with valid/ready, stall,    |
// |                  flush-to-bubble; PIPE_SKID_EN adds a 2-entry skid buffer.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEFAULT_CTRL_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  pipe_stage_reg_if.slave bus
);

  localparam int c_ENTRY_W = CTRL_W + DATA_W + ADDR_W;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_drain;
  logic                 w_main_load;
  logic                 w_main_clear;
  logic                 w_main_valid;
  logic [c_ENTRY_W-1:0] w_in_entry;
  logic [c_ENTRY_W-1:0] w_main_src;
  logic [c_ENTRY_W-1:0] w_main_entry;

  assign w_in_entry = {bus.ctrl_i, bus.data_i, bus.rd_i};

`ifdef PIPE_SKID_EN
  logic                 ready_q, ready_d;
  logic                 w_skid_load;
  logic                 w_skid_clear;
  logic                 w_skid_valid;
  logic [c_ENTRY_W-1:0] w_skid_entry;

  always_comb begin
    w_ready      = ready_q & ~bus.stall_i & ~bus.flush_i;
    w_accept     = bus.valid_i & w_ready;
    w_drain      = w_main_valid & bus.ready_i & ~bus.stall_i;
    w_main_load  = 1'b0;
    w_main_clear = 1'b0;
    w_main_src   = w_in_entry;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    if (bus.flush_i) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else if (!bus.stall_i) begin
      if (w_skid_valid) begin
        // Skid occupied means ready was low, so only a drain can happen here
        if (w_drain) begin
          w_main_load  = 1'b1;
          w_main_src   = w_skid_entry;
          w_skid_clear = 1'b1;
        end
      end else if (w_main_valid && !w_drain) begin
        w_skid_load = w_accept;
      end else if (w_accept) begin
        w_main_load = 1'b1;
      end else begin
        w_main_clear = w_drain;
      end
    end
    ready_d = ~(w_skid_load | (w_skid_valid & ~w_skid_clear));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= ready_d;
    end
  end

  pipe_skid_slot #(
    .CTRL_W    (CTRL_W),
    .PAYLOAD_W (DATA_W + ADDR_W)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_skid_load),
    .clear_i (w_skid_clear),
    .entry_i (w_in_entry),
    .valid_o (w_skid_valid),
    .entry_o (w_skid_entry)
  );
`else
  always_comb begin
    w_ready      = ~bus.stall_i & ~bus.flush_i & (~w_main_valid | bus.ready_i);
    w_accept     = bus.valid_i & w_ready;
    w_drain      = w_main_valid & bus.ready_i & ~bus.stall_i;
    w_main_src   = w_in_entry;
    w_main_load  = w_accept;
    w_main_clear = bus.flush_i | (w_drain & ~w_accept);
  end
`endif

  pipe_skid_slot #(
    .CTRL_W    (CTRL_W),
    .PAYLOAD_W (DATA_W + ADDR_W)
  ) u_main (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_main_load),
    .clear_i (w_main_clear),
    .entry_i (w_main_src),
    .valid_o (w_main_valid),
    .entry_o (w_main_entry)
  );

  assign bus.ready_o = w_ready;
  assign bus.valid_o = w_main_valid;
  assign {bus.ctrl_o, bus.data_o, bus.rd_o} = w_main_entry;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_stage_reg : directed and random stimulus against a queue model     |
// |                     of the stage occupancy.                                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_reg;
  import pipe_pkg::*;

`ifdef PIPE_SKID_EN
  localparam int c_CAP = 2;
`else
  localparam int c_CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  pipe_entry_t mq[$];
  pipe_entry_t last_e = '0;

  pipe_stage_reg_if bus_if ();

  pipe_stage_reg dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic model_ready(input logic st, input logic fl, input logic rdy);
    if (c_CAP == 1) return !st && !fl && (mq.size() == 0 || rdy);
    return !st && !fl && (mq.size() < c_CAP);
  endfunction

  function automatic logic [64:0] rand_data();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[64:0];
  endfunction

  task automatic check(input string tag, input logic st, input logic fl, input logic rdy);
    logic        exp_v;
    logic [3:0]  exp_c;
    logic [64:0] exp_d;
    logic [4:0]  exp_r;
    logic        exp_rdy;
    exp_v = (mq.size() > 0);
    if (exp_v) begin
      exp_c = mq[0].ctrl; exp_d = mq[0].data; exp_r = mq[0].rd;
    end else begin
      exp_c = '0; exp_d = last_e.data; exp_r = last_e.rd;
    end
    exp_rdy = model_ready(st, fl, rdy);
    n_cmp++;
    assert (bus_if.valid_o === exp_v) else begin
      n_err++; $error("FAIL %s valid_o got %b want %b", tag, bus_if.valid_o, exp_v);
    end
    n_cmp++;
    assert (bus_if.ready_o === exp_rdy) else begin
      n_err++; $error("FAIL %s ready_o got %b want %b", tag, bus_if.ready_o, exp_rdy);
    end
    n_cmp++;
    assert (bus_if.ctrl_o === exp_c) else begin
      n_err++; $error("FAIL %s ctrl_o got %h want %h", tag, bus_if.ctrl_o, exp_c);
    end
    n_cmp++;
    assert (bus_if.data_o === exp_d) else begin
      n_err++; $error("FAIL %s data_o got %h want %h", tag, bus_if.data_o, exp_d);
    end
    n_cmp++;
    assert (bus_if.rd_o === exp_r) else begin
      n_err++; $error("FAIL %s rd_o got %0d want %0d", tag, bus_if.rd_o, exp_r);
    end
  endtask

  // One clock: drive at negedge, check just after, then advance the model at posedge
  task automatic cycle(input logic r, input logic v, input logic [3:0] c, input logic [64:0] d,
                       input logic [4:0] rd, input logic st, input logic fl, input logic rdy,
                       input bit chk, input string tag);
    pipe_entry_t e;
    logic        acc, drn;
    @(negedge clk);
    rst            = r;
    bus_if.valid_i = v;
    bus_if.ctrl_i  = c;
    bus_if.data_i  = d;
    bus_if.rd_i    = rd;
    bus_if.stall_i = st;
    bus_if.flush_i = fl;
    bus_if.ready_i = rdy;
    #1;
    if (chk) check(tag, st, fl, rdy);
    acc = v && model_ready(st, fl, rdy);
    drn = (mq.size() > 0) && rdy;
    @(posedge clk);
    e.ctrl = c; e.data = d; e.rd = rd;
    if (r) begin
      mq.delete();
      last_e = '0;
    end else if (fl) begin
      mq.delete();
    end else if (!st) begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    if (mq.size() > 0) last_e = mq[0];
  endtask

  initial begin
    bus_if.valid_i = 1'b0;
    bus_if.ctrl_i  = '0;
    bus_if.data_i  = '0;
    bus_if.rd_i    = '0;
    bus_if.stall_i = 1'b0;
    bus_if.flush_i = 1'b0;
    bus_if.ready_i = 1'b0;

    // Reset with an active upstream entry
    cycle(1, 1, 4'hF, 65'h1_2345_6789, 5'd3, 0, 0, 0, 0, "reset0");
    cycle(1, 1, 4'hF, 65'h1_2345_6789, 5'd3, 0, 0, 0, 1, "reset1");
    cycle(0, 0, 4'h0, 65'h0, 5'd0, 0, 0, 0, 1, "after_reset");

    // Back-to-back streaming
    for (int i = 1; i <= 8; i++)
      cycle(0, 1, 4'($urandom_range(15, 0)), rand_data(), 5'(i), 0, 0, 1, 1, "stream");
    cycle(0, 0, 4'h0, 65'h0, 5'd0, 0, 0, 1, 1, "stream_tail");
    cycle(0, 0, 4'h0, 65'h0, 5'd0, 0, 0, 1, 1, "stream_empty");

    // Stall hold
    cycle(0, 1, 4'b1001, 65'h1_DEAD_BEEF, 5'd7, 0, 0, 0, 1, "stall_load");
    for (int i = 0; i < 3; i++)
      cycle(0, 1, 4'h6, 65'h0_1111_2222, 5'd9, 1, 0, 1, 1, "stall_hold");
    cycle(0, 0, 4'h0, 65'h0, 5'd0, 0, 0, 1, 1, "stall_release");
    cycle(0, 0, 4'h0, 65'h0, 5'd0, 0, 0, 1, 1, "stall_empty");

    // Flush drops held entry and the concurrent input
    cycle(0, 1, 4'b0011, 65'h0_CAFE_F00D, 5'd12, 0, 0, 0, 1, "flush_load");
    cycle(0, 1, 4'b1111, 65'h0_BAD0_BAD0, 5'd13, 1, 1, 0, 1, "flush_with_stall");
    cycle(0, 0, 4'h0, 65'h0, 5'd0, 0, 0, 1, 1, "flush_after");

    // Backpressure then release
    for (int i = 0; i < 4; i++)
      cycle(0, 1, 4'($urandom_range(15, 0)), rand_data(), 5'(20 + i), 0, 0, 0, 1, "bp_hold");
    for (int i = 0; i < 3; i++)
      cycle(0, 0, 4'h0, 65'h0, 5'd0, 0, 0, 1, 1, "bp_release");

    // Reset while stalled with the buffer full
    for (int i = 0; i < 3; i++)
      cycle(0, 1, 4'hA, rand_data(), 5'(26 + i), 0, 0, 0, 1, "fill");
    cycle(0, 1, 4'hA, 65'h0, 5'd30, 1, 0, 0, 1, "stall_full");
    cycle(1, 1, 4'hA, 65'h0, 5'd30, 1, 0, 0, 1, "reset_mid_stall");
    cycle(0, 0, 4'h0, 65'h0, 5'd0, 0, 0, 0, 1, "post_reset");

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(0, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), rand_data(),
            5'($urandom_range(31, 0)), ($urandom_range(9, 0) == 0),
            ($urandom_range(19, 0) == 0), ($urandom_range(3, 0) != 0), 1, "random");
    cycle(0, 0, 4'h0, 65'h0, 5'd0, 0, 0, 1, 1, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
